// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Define IFETCH_DEPTH2_EN to get a 2-entry instruction buffer (default 1).
package ifetch_pkg;

  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

`ifdef IFETCH_DEPTH2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory request/response bus between ifetch and memory.
interface ifetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (output mem_req_o, mem_addr_o,
                  input  mem_gnt_i, mem_rvalid_i, mem_rdata_i);
  modport slave  (input  mem_req_o, mem_addr_o,
                  output mem_gnt_i, mem_rvalid_i, mem_rdata_i);
endinterface

// File: rtl/ifetch_buf.sv
// Small shifting instruction buffer of {addr, inst} entries; flush wins
// over push/pop, simultaneous push and pop keep occupancy unchanged.
module ifetch_buf
  import ifetch_pkg::entry_t;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int CW = $clog2(DEPTH + 1);

  entry_t         mem_q [DEPTH];
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  wr_idx;
  logic           pop_eff, push_eff;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign head_o   = mem_q[0];
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);
  // Write slot accounts for the shift caused by a same-cycle pop.
  assign wr_idx   = cnt_q - CW'(pop_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      if (pop_eff)
        for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      if (push_eff)
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == wr_idx) mem_q[i] <= push_data_i;
      cnt_q <= cnt_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, single-outstanding request FSM and instruction buffer.
// Buffer depth is 1, or 2 when IFETCH_DEPTH2_EN is defined.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  ifetch_if.master    mem,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  state_e      st_q;
  logic [31:0] pc_q, iss_q;
  logic [31:0] jump_pc;
  logic        req, pop, push;
  logic        buf_full, buf_empty;
  entry_t      head;

  assign jump_pc = jump_addr_i & 32'hFFFF_FFFC;
  assign pop     = !buf_empty && !hold_i && !jump_en_i;
  assign push    = (st_q == ST_WAIT) && mem.mem_rvalid_i && !jump_en_i;
  // A popping full buffer frees a slot in time for the response.
  assign req     = rst_n && (st_q == ST_IDLE) && !jump_en_i && (!buf_full || pop);

  assign mem.mem_req_o  = req;
  assign mem.mem_addr_o = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      pc_q  <= RESET_PC;
      iss_q <= '0;
    end else begin
      if (jump_en_i) begin
        pc_q <= jump_pc;
      end else if (req && mem.mem_gnt_i) begin
        pc_q  <= pc_q + 32'd4;
        iss_q <= pc_q;
      end
      case (st_q)
        ST_IDLE: if (req && mem.mem_gnt_i) st_q <= ST_WAIT;
        ST_WAIT: begin
          if (mem.mem_rvalid_i) st_q <= ST_IDLE;
          else if (jump_en_i)   st_q <= ST_DROP;
        end
        ST_DROP: if (mem.mem_rvalid_i) st_q <= ST_IDLE;
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  ifetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i('{addr: iss_q, inst: mem.mem_rdata_i}),
    .pop_i      (pop),
    .flush_i    (jump_en_i),
    .head_o     (head),
    .full_o     (buf_full),
    .empty_o    (buf_empty)
  );

  assign inst_valid_o = !buf_empty;
  assign inst_o       = buf_empty ? INST_NOP : head.inst;
  assign inst_addr_o  = buf_empty ? 32'h0    : head.addr;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: per-cycle vector table plus hand sequences for
// hold/backpressure, flush and mid-request reset.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en, hold;
  logic [31:0] jump_addr;
  logic [31:0] inst_addr, inst;
  logic        inst_valid;
  int          checks = 0;
  int          errors = 0;

  ifetch_if mif ();

  ifetch #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_en_i   (jump_en),
    .jump_addr_i (jump_addr),
    .hold_i      (hold),
    .mem         (mif.master),
    .inst_addr_o (inst_addr),
    .inst_o      (inst),
    .inst_valid_o(inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, jmp;
    logic [31:0] ja;
    logic        hld, gnt, rv;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins, ia;
  } vec_t;

  function automatic vec_t mv(logic r, logic j, logic [31:0] ja, logic h, logic g,
                              logic rv, logic [31:0] rd, logic q, logic [31:0] a,
                              logic vl, logic [31:0] in, logic [31:0] ia);
    vec_t v;
    v.rst = r; v.jmp = j; v.ja = ja; v.hld = h; v.gnt = g; v.rv = rv; v.rd = rd;
    v.req = q; v.addr = a; v.vld = vl; v.ins = in; v.ia = ia;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic j, input logic [31:0] ja, input logic h,
                       input logic g, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    rst_n = r; jump_en = j; jump_addr = ja; hold = h;
    mif.mem_gnt_i = g; mif.mem_rvalid_i = rv; mif.mem_rdata_i = rd;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  vec_t vecs [23];
  logic [31:0] pcx;

  initial begin
    jump_en = 0; jump_addr = 0; hold = 0;
    mif.mem_gnt_i = 0; mif.mem_rvalid_i = 0; mif.mem_rdata_i = 0;

    //              rst j  ja        h  g  rv rdata          req addr     vld inst           iaddr
    vecs[0]  = mv(0, 0, 32'h0,   0, 0, 0, 32'h0,         0, 32'h0,   0, INST_NOP,      32'h0);
    vecs[1]  = mv(1, 0, 32'h0,   0, 1, 0, 32'h0,         1, 32'h0,   0, INST_NOP,      32'h0);
    vecs[2]  = mv(1, 0, 32'h0,   0, 1, 1, 32'hAAAA_0000, 0, 32'h4,   0, INST_NOP,      32'h0);
    vecs[3]  = mv(1, 0, 32'h0,   0, 1, 0, 32'h0,         1, 32'h4,   1, 32'hAAAA_0000, 32'h0);
    vecs[4]  = mv(1, 0, 32'h0,   0, 0, 1, 32'hAAAA_0001, 0, 32'h8,   0, INST_NOP,      32'h0);
    vecs[5]  = mv(1, 0, 32'h0,   0, 1, 0, 32'h0,         1, 32'h8,   1, 32'hAAAA_0001, 32'h4);
    vecs[6]  = mv(1, 0, 32'h0,   0, 0, 1, 32'hAAAA_0002, 0, 32'hC,   0, INST_NOP,      32'h0);
    vecs[7]  = mv(1, 0, 32'h0,   0, 0, 0, 32'h0,         1, 32'hC,   1, 32'hAAAA_0002, 32'h8);
    vecs[8]  = mv(1, 0, 32'h0,   0, 0, 0, 32'h0,         1, 32'hC,   0, INST_NOP,      32'h0);
    vecs[9]  = mv(1, 0, 32'h0,   0, 0, 0, 32'h0,         1, 32'hC,   0, INST_NOP,      32'h0);
    vecs[10] = mv(1, 0, 32'h0,   0, 1, 0, 32'h0,         1, 32'hC,   0, INST_NOP,      32'h0);
    vecs[11] = mv(1, 1, 32'h100, 0, 0, 0, 32'h0,         0, 32'h10,  0, INST_NOP,      32'h0);
    vecs[12] = mv(1, 0, 32'h0,   0, 0, 1, 32'hDEAD_0000, 0, 32'h100, 0, INST_NOP,      32'h0);
    vecs[13] = mv(1, 0, 32'h0,   0, 1, 0, 32'h0,         1, 32'h100, 0, INST_NOP,      32'h0);
    vecs[14] = mv(1, 1, 32'h203, 0, 0, 1, 32'hBEEF_0000, 0, 32'h104, 0, INST_NOP,      32'h0);
    vecs[15] = mv(1, 0, 32'h0,   0, 0, 0, 32'h0,         1, 32'h200, 0, INST_NOP,      32'h0);
    vecs[16] = mv(1, 0, 32'h0,   0, 1, 0, 32'h0,         1, 32'h200, 0, INST_NOP,      32'h0);
    vecs[17] = mv(1, 0, 32'h0,   0, 0, 1, 32'hAAAA_0003, 0, 32'h204, 0, INST_NOP,      32'h0);
    vecs[18] = mv(1, 0, 32'h0,   0, 0, 0, 32'h0,         1, 32'h204, 1, 32'hAAAA_0003, 32'h200);
    vecs[19] = mv(1, 1, 32'h400, 0, 1, 0, 32'h0,         0, 32'h204, 0, INST_NOP,      32'h0);
    vecs[20] = mv(1, 0, 32'h0,   0, 0, 0, 32'h0,         1, 32'h400, 0, INST_NOP,      32'h0);
    vecs[21] = mv(1, 0, 32'h0,   0, 0, 1, 32'hBAD0_0000, 1, 32'h400, 0, INST_NOP,      32'h0);
    vecs[22] = mv(1, 0, 32'h0,   0, 0, 0, 32'h0,         1, 32'h400, 0, INST_NOP,      32'h0);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].jmp, vecs[i].ja, vecs[i].hld, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
      chk($sformatf("v%0d req", i),   {31'b0, mif.mem_req_o}, {31'b0, vecs[i].req});
      chk($sformatf("v%0d addr", i),  mif.mem_addr_o,         vecs[i].addr);
      chk($sformatf("v%0d vld", i),   {31'b0, inst_valid},    {31'b0, vecs[i].vld});
      chk($sformatf("v%0d inst", i),  inst,                   vecs[i].ins);
      chk($sformatf("v%0d iaddr", i), inst_addr,              vecs[i].ia);
    end

    // Hold for 5 cycles with gnt/rvalid held high; rvalid in IDLE is ignored.
    drive(1, 0, 0, 1, 1, 1, 32'hB000_0000);
    chk("hold0 req", {31'b0, mif.mem_req_o}, 32'd1);
    chk("hold0 addr", mif.mem_addr_o, 32'h400);
    drive(1, 0, 0, 1, 1, 1, 32'hB000_0001);
    chk("hold1 req", {31'b0, mif.mem_req_o}, 32'd0);
    chk("hold1 vld", {31'b0, inst_valid}, 32'd0);
    drive(1, 0, 0, 1, 1, 1, 32'hB000_0002);
    chk("hold2 inst", inst, 32'hB000_0001);
    chk("hold2 iaddr", inst_addr, 32'h400);
    chk("hold2 req", {31'b0, mif.mem_req_o}, (DEPTH > 1) ? 32'd1 : 32'd0);
    drive(1, 0, 0, 1, 1, 1, 32'hB000_0003);
    chk("hold3 inst", inst, 32'hB000_0001);
    chk("hold3 req", {31'b0, mif.mem_req_o}, 32'd0);
    drive(1, 0, 0, 1, 1, 1, 32'hB000_0004);
    chk("hold4 inst", inst, 32'hB000_0001);
    chk("hold4 vld", {31'b0, inst_valid}, 32'd1);
    chk("hold4 req", {31'b0, mif.mem_req_o}, 32'd0);

    pcx = (DEPTH > 1) ? 32'h408 : 32'h404;
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    chk("rel0 inst", inst, 32'hB000_0001);
    chk("rel0 req", {31'b0, mif.mem_req_o}, 32'd1);
    chk("rel0 addr", mif.mem_addr_o, pcx);
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    chk("rel1 vld", {31'b0, inst_valid}, (DEPTH > 1) ? 32'd1 : 32'd0);
    chk("rel1 inst", inst, (DEPTH > 1) ? 32'hB000_0003 : INST_NOP);
    chk("rel1 iaddr", inst_addr, (DEPTH > 1) ? 32'h404 : 32'h0);
    drive(1, 0, 0, 0, 1, 0, 32'h0);
    chk("rel2 vld", {31'b0, inst_valid}, 32'd0);
    chk("rel2 addr", mif.mem_addr_o, pcx);

    // Jump while an instruction is buffered and held flushes it.
    drive(1, 0, 0, 0, 0, 1, 32'hC000_0000);
    chk("fl0 req", {31'b0, mif.mem_req_o}, 32'd0);
    drive(1, 1, 32'h800, 1, 1, 0, 32'h0);
    chk("fl1 inst", inst, 32'hC000_0000);
    chk("fl1 iaddr", inst_addr, pcx);
    chk("fl1 req", {31'b0, mif.mem_req_o}, 32'd0);
    drive(1, 0, 0, 1, 0, 0, 32'h0);
    chk("fl2 vld", {31'b0, inst_valid}, 32'd0);
    chk("fl2 inst", inst, INST_NOP);
    chk("fl2 addr", mif.mem_addr_o, 32'h800);

    // Reset during WAIT; the stale response after release must be ignored.
    drive(1, 0, 0, 0, 1, 0, 32'h0);
    chk("rw0 req", {31'b0, mif.mem_req_o}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    chk("rst req", {31'b0, mif.mem_req_o}, 32'd0);
    chk("rst addr", mif.mem_addr_o, 32'h0);
    chk("rst vld", {31'b0, inst_valid}, 32'd0);
    chk("rst inst", inst, INST_NOP);
    drive(1, 0, 0, 0, 0, 1, 32'h5A1E_0000);
    chk("post req", {31'b0, mif.mem_req_o}, 32'd1);
    chk("post addr", mif.mem_addr_o, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    chk("stale vld", {31'b0, inst_valid}, 32'd0);
    chk("stale inst", inst, INST_NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
